// File: rtl/pipe_reg_valid.sv
// Purpose: WIDTH-bit, DEPTH-stage pipeline register with per-stage valid, global advance enable and synchronous flush.
// Latency: DEPTH enabled clock edges from capture at stage 0 to out/out_valid; stalled cycles add one-for-one.
// Backpressure: none; enable=0 freezes every stage, and the operand leaving the last stage is dropped.
// Optional feature: define PIPE_REG_COUNT_EN to add the registered occupancy output 'count'.
module pipe_reg_valid #(
    parameter int WIDTH        = 10,
    parameter int DEPTH        = 3,
    parameter int ZERO_INVALID = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic             enable,
    input  logic             flush,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             busy
`ifdef PIPE_REG_COUNT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

    // Dead stages are forced to zero only when switching-activity gating is enabled.
    localparam bit GATE = (ZERO_INVALID != 0);

    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] v;

    // Data entering a stage: passed through, or zeroed when gating and the incoming valid is low.
    function automatic logic [WIDTH-1:0] gate_data(input logic [WIDTH-1:0] d, input logic vld);
        return (GATE && !vld) ? '0 : d;
    endfunction

    // Stage registers: reset beats flush beats enable; otherwise everything holds.
    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            v <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data[k] <= '0;
            end
        end else if (enable) begin
            v[0]    <= in_valid;
            data[0] <= gate_data(in, in_valid);
            for (int k = 1; k < DEPTH; k++) begin
                v[k]    <= v[k-1];
                data[k] <= gate_data(data[k-1], v[k-1]);
            end
        end
    end

    assign out       = data[DEPTH-1];
    assign out_valid = v[DEPTH-1];
    assign busy      = |v;

`ifdef PIPE_REG_COUNT_EN
    localparam int CNT_W = $clog2(DEPTH+1);

    // Occupancy tracked incrementally: +1 on entry, -1 on exit, both only on advancing edges.
    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(in_valid) - CNT_W'(v[DEPTH-1]);
        end
    end
`endif

endmodule

// File: doc/pipe_reg_valid.md
Name: pipe_reg_valid

Overview:
- Parametrised successor to the fixed 10-bit register: a WIDTH-bit, DEPTH-stage pipeline register with per-stage valid tracking, a global advance enable (stall), and a synchronous flush.
- Sits between the pipelined stages of the arithmetic datapaths (multiplier/adder trees) so that stage depth and width are set per instance.
- Also lets stalls and pipeline kills propagate without corrupting in-flight operands.

Parameters:
- WIDTH, 10, data width in bits (>=1).
- DEPTH, 3, number of register stages (>=1); latency in enabled cycles.
- ZERO_INVALID, 0, when 1 a stage captures all-zero data whenever its incoming valid is 0 (switching-activity gating); when 0 data is captured regardless of valid.

Ports:
- clock  input  1  rising-edge clock for all state.
- reset_n  input  1  synchronous active-low reset, sampled on rising edge of clock.
- in  input  WIDTH  operand entering stage 0.
- in_valid  input  1  in carries a live operand.
- enable  input  1  1 = pipeline advances one stage this cycle; 0 = all stages hold.
- flush  input  1  synchronous kill of every in-flight operand.
- out  output  WIDTH  data of last stage (DEPTH-1).
- out_valid  output  1  valid bit of last stage.
- busy  output  1  OR of all stage valid bits.

Behaviour:
- State: data[0..DEPTH-1] (WIDTH each), v[0..DEPTH-1]. All registered; out = data[DEPTH-1], out_valid = v[DEPTH-1], busy = |v (combinational from registers, no input feed-through).
- Reset (reset_n=0 at a clock edge): all data = 0, all v = 0, so out = 0, out_valid = 0, busy = 0. Reset dominates flush and enable. Reset mid-operation discards all operands; the first capture after release is on the first edge with reset_n=1.
- Priority per edge: reset_n=0 > flush=1 > enable=1 > hold.
- flush=1: all v cleared to 0; all data cleared to 0. The current in/in_valid is dropped even if enable=1. busy=0 the next cycle.
- enable=1, no flush: v[0] <= in_valid; data[0] <= in (or 0 if ZERO_INVALID=1 and in_valid=0). For k>=1: v[k] <= v[k-1]; data[k] <= data[k-1] (or 0 if ZERO_INVALID=1 and v[k-1]=0). The operand leaving stage DEPTH-1 is lost; no back-pressure exists.
- enable=0, no flush: every data and v holds. in/in_valid are ignored (not captured).
- Latency: an operand accepted at edge N appears at out with out_valid=1 after exactly DEPTH enabled edges (counting edge N). Stalled cycles add 1:1.
- DEPTH=1: single register with valid; busy == out_valid.
- Bubbles (in_valid=0) propagate like operands; back-to-back valids give one result per enabled cycle.

Optional Feature:
- Macro: PIPE_REG_COUNT_EN.
- Defined: adds output port count, width $clog2(DEPTH+1), placed after busy. It is a registered occupancy counter, reset to 0 and flush to 0.
- On an enabled edge, count += in_valid and count -= v[DEPTH-1]; simultaneous entry and exit leaves it unchanged. It holds when enable=0.
- count must always equal the popcount of v. It is implemented as an up/down counter, not a popcount.
- Not defined: port count absent; no counter logic.

Test Plan:
- Reset: drive in=10'h3FF, in_valid=1, enable=1, reset_n=0 for 3 edges -> out=0, out_valid=0, busy=0 (count=0). Release; next capture happens on the first edge with reset_n=1.
- Latency (WIDTH=10, DEPTH=3): reset_n=1, enable=1, in=10'h2A5 with in_valid=1 for one cycle, then in_valid=0 -> out=10'h2A5 with out_valid=1 exactly 3 edges later, for one cycle only. busy high for 3 cycles.
- Stall: stream 10'h001, 10'h002, 10'h003; drop enable for 2 cycles after the second is accepted -> outputs hold. Results 001, 002, 003 emerge in order, total latency 3+2 edges for the stalled operands, no duplicates.
- Flush: fill all 3 stages with valid data, assert flush and enable together with in=10'h155, in_valid=1 -> next cycle busy=0, out_valid=0, out=0. 10'h155 never appears.
- ZERO_INVALID=1: alternate in_valid 1/0 with in=10'h3FF constant -> out alternates 10'h3FF/10'h000 in step with out_valid.
- PIPE_REG_COUNT_EN: continuous valid input for 5 cycles then none, DEPTH=3 -> count goes 1,2,3,3,3,2,1,0. After refilling to 2, flush -> count=0 next cycle.
